// File: rtl/hazard_control_if.sv
// hazard_control_if: ID/EX hazard inputs and stall/flush controls of the pipeline sequencer
interface hazard_control_if #(parameter int REG_SIZE = 5, parameter int CNT_WIDTH = 32);
  logic [REG_SIZE-1:0]  id_rs;
  logic [REG_SIZE-1:0]  id_rt;
  logic                 id_uses_rs;
  logic                 id_uses_rt;
  logic                 ex_mem_read;
  logic [REG_SIZE-1:0]  ex_rt;
  logic                 branch_taken;
  logic                 multi_start;
  logic                 pc_write;
  logic                 if_id_write;
  logic                 if_id_flush;
  logic                 id_ex_write;
  logic                 id_ex_bubble;
  logic                 ex_mem_bubble;
  logic                 busy;
  logic                 multi_done;
  logic [CNT_WIDTH-1:0] stall_cycles;
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt, branch_taken, multi_start,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, busy,
           multi_done, stall_cycles
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt, branch_taken, multi_start,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, busy,
           multi_done, stall_cycles
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, branch flush and multi-cycle EX freeze with a saturating stall counter
module hazard_control_unit #(
  parameter int REG_SIZE      = 5,
  parameter int MULTI_LATENCY = 4,
  parameter int CNT_WIDTH     = 32
) (
  input logic clk,
  input logic rst,
  hazard_control_if.slave hif
);
  localparam int MW = $clog2(MULTI_LATENCY);
  typedef enum logic {RUN, MULTI} state_t;
  state_t               state_q, state_d;
  logic [MW-1:0]        mcnt_q, mcnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 multi, lu, br, ms, lus, frz;
  always_comb begin
    multi = state_q == MULTI;
    lu    = hif.ex_mem_read && hif.ex_rt != REG_SIZE'(0) &&
            ((hif.id_uses_rs && hif.id_rs == hif.ex_rt) || (hif.id_uses_rt && hif.id_rt == hif.ex_rt));
    br    = !multi && hif.branch_taken;
    ms    = !multi && !hif.branch_taken && hif.multi_start;
    lus   = !multi && !hif.branch_taken && !hif.multi_start && lu;
    frz   = multi || ms;
    hif.pc_write      = !(frz || lus);
    hif.if_id_write   = !(frz || lus);
    hif.id_ex_write   = !frz;
    hif.if_id_flush   = br;
    hif.id_ex_bubble  = br || lus;
    hif.ex_mem_bubble = frz;
    hif.busy          = multi;
    hif.multi_done    = multi && mcnt_q == '0;
    hif.stall_cycles  = cnt_q;
    state_d = ms ? MULTI : (hif.multi_done ? RUN : state_q);
    mcnt_d  = ms ? MW'(MULTI_LATENCY - 2) : (multi && mcnt_q != '0 ? mcnt_q - 1'b1 : mcnt_q);
    cnt_d   = !hif.pc_write && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      mcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed and random stimulus against a frozen-cycles-remaining reference model
module tb_hazard_control_unit;
  localparam int L = 4;
  logic clk = 0;
  logic rst;
  int compared = 0;
  int mismatched = 0;
  int fl = 0;
  longint s32 = 0;
  int s4 = 0;
  hazard_control_if #(.REG_SIZE(5), .CNT_WIDTH(32)) i32 ();
  hazard_control_if #(.REG_SIZE(5), .CNT_WIDTH(4))  i4 ();
  hazard_control_unit #(.REG_SIZE(5), .MULTI_LATENCY(L), .CNT_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .hif(i32.slave));
  hazard_control_unit #(.REG_SIZE(5), .MULTI_LATENCY(L), .CNT_WIDTH(4))  dut4  (.clk(clk), .rst(rst), .hif(i4.slave));
  assign i4.id_rs        = i32.id_rs;
  assign i4.id_rt        = i32.id_rt;
  assign i4.id_uses_rs   = i32.id_uses_rs;
  assign i4.id_uses_rt   = i32.id_uses_rt;
  assign i4.ex_mem_read  = i32.ex_mem_read;
  assign i4.ex_rt        = i32.ex_rt;
  assign i4.branch_taken = i32.branch_taken;
  assign i4.multi_start  = i32.multi_start;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, busy, multi_done}
  task automatic step(input bit r, input int rs, input int rt, input bit urs, input bit urt,
                      input bit mr, input int ert, input bit br, input bit ms, input bit en);
    logic [7:0] exp, obs;
    bit lu;
    @(negedge clk);
    rst = r;
    i32.id_rs = 5'(rs); i32.id_rt = 5'(rt); i32.id_uses_rs = urs; i32.id_uses_rt = urt;
    i32.ex_mem_read = mr; i32.ex_rt = 5'(ert); i32.branch_taken = br; i32.multi_start = ms;
    #1;
    lu = mr && ert != 0 && ((urs && rs == ert) || (urt && rt == ert));
    if (fl > 0)  exp = {6'b000001, 1'b1, fl == 1};
    else if (br) exp = 8'b11111000;
    else if (ms) exp = 8'b00000100;
    else if (lu) exp = 8'b00011000;
    else         exp = 8'b11010000;
    obs = {i32.pc_write, i32.if_id_write, i32.if_id_flush, i32.id_ex_write, i32.id_ex_bubble,
           i32.ex_mem_bubble, i32.busy, i32.multi_done};
    if (en) begin
      chk("ctl32", 32'(obs), 32'(exp));
      chk("ctl4", 32'({i4.pc_write, i4.if_id_write, i4.if_id_flush, i4.id_ex_write, i4.id_ex_bubble,
                       i4.ex_mem_bubble, i4.busy, i4.multi_done}), 32'(exp));
      chk("stall32", i32.stall_cycles, 32'(s32));
      chk("stall4", 32'(i4.stall_cycles), 32'(s4));
    end
    @(posedge clk);
    if (r) begin
      fl = 0; s32 = 0; s4 = 0;
    end else begin
      if (!exp[7]) begin
        s32 = s32 + 1;
        if (s4 < 15) s4 = s4 + 1;
      end
      fl = fl > 0 ? fl - 1 : (!br && ms ? L - 1 : 0);
    end
  endtask
  task automatic idle(input bit en);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, en);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_pc", 32'(i32.pc_write), 1);
    chk("rst_busy", 32'(i32.busy), 0);
    chk("rst_cnt", i32.stall_cycles, 0);
    idle(1);
    step(0, 6, 0, 1, 0, 1, 6, 0, 0, 1);
    idle(1);
    chk("lu_cnt", i32.stall_cycles, 1);
    step(0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    step(0, 6, 0, 0, 0, 1, 6, 0, 0, 1);
    step(0, 3, 7, 0, 1, 1, 7, 0, 0, 1);
    step(0, 6, 0, 1, 0, 1, 6, 1, 0, 1);
    idle(1);
    chk("br_cnt", i32.stall_cycles, 2);
    step(0, 6, 0, 1, 0, 1, 6, 0, 1, 1);
    repeat (3) step(0, 6, 0, 1, 0, 1, 6, 1, 1, 1);
    step(0, 6, 0, 1, 0, 1, 6, 0, 0, 1);
    idle(1);
    chk("multi_cnt", i32.stall_cycles, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    chk("mid_rst_busy", 32'(i32.busy), 0);
    repeat (400) begin
      step($urandom_range(49) == 0, $urandom_range(3), $urandom_range(3), 1'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(3), $urandom_range(7) == 0, $urandom_range(9) == 0, 1);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (20) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    chk("sat4", 32'(i4.stall_cycles), 15);
    chk("cnt20", i32.stall_cycles, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
